// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pkg
// Brief   : Opcodes, forwarding encodings and FSM states for the pipeline
//           hazard / run controller.
// Rev     : 1.0
// ============================================================================
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef logic [1:0] fwd_t;
    localparam fwd_t FWD_RF   = 2'b00;
    localparam fwd_t FWD_EALU = 2'b01;
    localparam fwd_t FWD_MALU = 2'b10;
    localparam fwd_t FWD_MDM  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_RUN     = 2'd0;
    localparam state_t ST_LDSTALL = 2'd1;
    localparam state_t ST_HALT    = 2'd2;
    localparam state_t ST_STEP    = 2'd3;

    function automatic logic uses_rs(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Pipeline-status inputs and control outputs of hazard_ctrl.
// Rev     : 1.0
// ============================================================================
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [31:0]      instruction;
    logic             ewreg;
    logic             em2reg;
    logic [4:0]       erdrt_output;
    logic             mwreg;
    logic             mm2reg;
    logic [4:0]       mrdrt_output;
    logic             halt_req;
    logic             step_req;
    logic             wpcir;
    logic             bubble;
    fwd_t             fwda;
    fwd_t             fwdb;
    logic             step_ack;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output instruction, ewreg, em2reg, erdrt_output,
               mwreg, mm2reg, mrdrt_output, halt_req, step_req,
        input  wpcir, bubble, fwda, fwdb, step_ack, halted,
               cycle_cnt, stall_cnt, bubble_cnt
    );

    modport slave (
        input  instruction, ewreg, em2reg, erdrt_output,
               mwreg, mm2reg, mrdrt_output, halt_req, step_req,
        output wpcir, bubble, fwda, fwdb, step_ack, halted,
               cycle_cnt, stall_cnt, bubble_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : hazard_fwd_sel
// Brief   : Forwarding source select for one ID-stage operand; EXE beats MEM.
// Rev     : 1.0
// ============================================================================
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  wire logic       i_use,
    input  wire logic [4:0] i_src,
    input  wire logic       i_ewreg,
    input  wire logic       i_em2reg,
    input  wire logic [4:0] i_erd,
    input  wire logic       i_mwreg,
    input  wire logic       i_mm2reg,
    input  wire logic [4:0] i_mrd,
    output fwd_t            o_sel
);
    logic w_live;
    logic w_e_hit;
    logic w_m_hit;

    // r0 is hardwired to zero, so a write to it is never a real producer
    assign w_live  = i_use && (i_src != 5'd0);
    assign w_e_hit = w_live && i_ewreg && (i_erd == i_src);
    assign w_m_hit = w_live && i_mwreg && (i_mrd == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (w_e_hit && !i_em2reg)
            o_sel = FWD_EALU;
        else if (w_m_hit && !i_mm2reg)
            o_sel = FWD_MALU;
        else if (w_m_hit && i_mm2reg)
            o_sel = FWD_MDM;
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use stall, forwarding, halt/single-step run control and
//           saturating performance counters for the 5-stage pipeline.
// Rev     : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  wire logic   clk,
    input  wire logic   rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_use_rs;
    logic             w_use_rt;
    logic             w_ldh;
    logic             w_wpcir;
    logic             w_bubble;
    logic             w_stall;
    logic             w_step_done;
    logic             w_unused_imm;
    state_t           r_state;
    state_t           w_next;
    logic             r_step_ack;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_op         = bus.instruction[31:26];
    assign w_rs         = bus.instruction[25:21];
    assign w_rt         = bus.instruction[20:16];
    assign w_unused_imm = ^bus.instruction[15:0];
    assign w_use_rs     = uses_rs(w_op);
    assign w_use_rt     = uses_rt(w_op);

    assign w_ldh = bus.ewreg && bus.em2reg && (bus.erdrt_output != 5'd0) &&
                   ((w_use_rs && (bus.erdrt_output == w_rs)) ||
                    (w_use_rt && (bus.erdrt_output == w_rt)));

    hazard_fwd_sel u_fwd_a (
        .i_use    (w_use_rs),
        .i_src    (w_rs),
        .i_ewreg  (bus.ewreg),
        .i_em2reg (bus.em2reg),
        .i_erd    (bus.erdrt_output),
        .i_mwreg  (bus.mwreg),
        .i_mm2reg (bus.mm2reg),
        .i_mrd    (bus.mrdrt_output),
        .o_sel    (bus.fwda)
    );

    hazard_fwd_sel u_fwd_b (
        .i_use    (w_use_rt),
        .i_src    (w_rt),
        .i_ewreg  (bus.ewreg),
        .i_em2reg (bus.em2reg),
        .i_erd    (bus.erdrt_output),
        .i_mwreg  (bus.mwreg),
        .i_mm2reg (bus.mm2reg),
        .i_mrd    (bus.mrdrt_output),
        .o_sel    (bus.fwdb)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.halt_req)   w_next = ST_HALT;
                else if (w_ldh)     w_next = ST_LDSTALL;
            end
            ST_LDSTALL:             w_next = bus.halt_req ? ST_HALT : ST_RUN;
            ST_HALT: begin
                if (!bus.halt_req)  w_next = ST_RUN;
                else if (bus.step_req) w_next = ST_STEP;
            end
            ST_STEP: begin
                if (!w_ldh)         w_next = ST_HALT;
            end
            default:                w_next = ST_RUN;
        endcase
    end

    always_comb begin
        w_wpcir     = 1'b1;
        w_bubble    = 1'b0;
        w_stall     = 1'b0;
        w_step_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_wpcir  = !(w_ldh || bus.halt_req);
                w_bubble = w_ldh || bus.halt_req;
                w_stall  = w_ldh;
            end
            ST_LDSTALL: begin
                w_wpcir  = 1'b1;
                w_bubble = 1'b0;
            end
            ST_HALT: begin
                w_wpcir  = 1'b0;
                w_bubble = 1'b1;
            end
            ST_STEP: begin
                w_wpcir     = !w_ldh;
                w_bubble    = w_ldh;
                w_stall     = w_ldh;
                w_step_done = !w_ldh;
            end
            default: begin
                w_wpcir  = 1'b0;
                w_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_ack   <= 1'b0;
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_step_ack <= w_step_done;
            if (r_cycle_cnt != c_cnt_max)
                r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
            if (w_stall && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (w_bubble && (r_bubble_cnt != c_cnt_max))
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
        end
    end

    assign bus.wpcir      = w_wpcir;
    assign bus.bubble     = w_bubble;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.step_ack   = r_step_ack;
    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed self-checking bench for hazard_ctrl (32-bit and 4-bit
//           counter instances).
// Rev     : 1.0
// ============================================================================
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    int   e_cyc;
    int   e_stall;
    int   e_bub;

    hazard_ctrl_if #(.CNT_W(32)) bus ();
    hazard_ctrl_if #(.CNT_W(4))  sbus ();

    hazard_ctrl #(.CNT_W(32)) dut     (.clk(clk), .rst(rst), .bus(bus));
    hazard_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .rst(rst), .bus(sbus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input bit b, input bit s);
        e_cyc++;
        e_bub   += int'(b);
        e_stall += int'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag, input logic w, input logic b,
                              input logic [1:0] fa, input logic [1:0] fb);
        #1;
        check({tag, ".wpcir"},  {31'd0, bus.wpcir},  {31'd0, w});
        check({tag, ".bubble"}, {31'd0, bus.bubble}, {31'd0, b});
        check({tag, ".fwda"},   {30'd0, bus.fwda},   {30'd0, fa});
        check({tag, ".fwdb"},   {30'd0, bus.fwdb},   {30'd0, fb});
    endtask

    task automatic check_cnt(input string tag);
        check({tag, ".cycle"},  bus.cycle_cnt,  e_cyc);
        check({tag, ".stall"},  bus.stall_cnt,  e_stall);
        check({tag, ".bubble"}, bus.bubble_cnt, e_bub);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        e_cyc = 0; e_stall = 0; e_bub = 0;
        check({tag, ".halted"}, {31'd0, bus.halted},   32'd0);
        check({tag, ".ack"},    {31'd0, bus.step_ack}, 32'd0);
        check_cnt(tag);
        rst = 1'b0;
    endtask

    task automatic clr_pipe;
        bus.ewreg = 1'b0; bus.em2reg = 1'b0; bus.erdrt_output = 5'd0;
        bus.mwreg = 1'b0; bus.mm2reg = 1'b0; bus.mrdrt_output = 5'd0;
    endtask

    function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] mk_mem(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sbus.instruction = 32'd0; sbus.ewreg = 1'b0; sbus.em2reg = 1'b0;
        sbus.erdrt_output = 5'd0; sbus.mwreg = 1'b0; sbus.mm2reg = 1'b0;
        sbus.mrdrt_output = 5'd0; sbus.halt_req = 1'b0; sbus.step_req = 1'b0;
        bus.instruction = 32'd0; bus.halt_req = 1'b0; bus.step_req = 1'b0;
        clr_pipe();
        e_cyc = 0; e_stall = 0; e_bub = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset("rst");

        check_comb("idle", 1'b1, 1'b0, FWD_RF, FWD_RF);
        tick(0, 0);

        // add r6,r2,r10 behind a load of r2
        bus.instruction = mk_add(5'd6, 5'd2, 5'd10);
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.erdrt_output = 5'd2;
        check_comb("ldu", 1'b0, 1'b1, FWD_RF, FWD_RF);
        check("ldu.stall0", bus.stall_cnt, 32'd0);
        tick(1, 1);
        check("ldu.stall1", bus.stall_cnt, 32'd1);
        clr_pipe();
        bus.mwreg = 1'b1; bus.mm2reg = 1'b1; bus.mrdrt_output = 5'd2;
        check_comb("ldu.mem", 1'b1, 1'b0, FWD_MDM, FWD_RF);
        tick(0, 0);

        bus.instruction = mk_add(5'd1, 5'd5, 5'd5);
        bus.ewreg = 1'b1; bus.em2reg = 1'b0; bus.erdrt_output = 5'd5;
        bus.mwreg = 1'b1; bus.mm2reg = 1'b0; bus.mrdrt_output = 5'd5;
        check_comb("prio.exe", 1'b1, 1'b0, FWD_EALU, FWD_EALU);
        bus.ewreg = 1'b0;
        check_comb("prio.mem", 1'b1, 1'b0, FWD_MALU, FWD_MALU);
        tick(0, 0);

        // lw r2,0(r0): rs is r0, rt is a destination
        clr_pipe();
        bus.instruction = mk_mem(OP_LW, 5'd0, 5'd2);
        bus.ewreg = 1'b1; bus.erdrt_output = 5'd0;
        check_comb("lw.r0", 1'b1, 1'b0, FWD_RF, FWD_RF);
        bus.em2reg = 1'b1; bus.erdrt_output = 5'd2;
        check_comb("lw.rt", 1'b1, 1'b0, FWD_RF, FWD_RF);
        tick(0, 0);

        // sw r2,0(r4) uses rt, so a pending load of r2 stalls it
        bus.instruction = mk_mem(OP_SW, 5'd4, 5'd2);
        check_comb("sw.rt", 1'b0, 1'b1, FWD_RF, FWD_RF);
        tick(1, 1);
        clr_pipe();
        check_comb("sw.ldst", 1'b1, 1'b0, FWD_RF, FWD_RF);
        tick(0, 0);
        check_cnt("pre_halt");

        bus.instruction = 32'd0;
        bus.halt_req = 1'b1;
        check_comb("halt.req", 1'b0, 1'b1, FWD_RF, FWD_RF);
        tick(1, 0);
        for (int i = 0; i < 3; i++) begin
            check("halt.halted", {31'd0, bus.halted}, 32'd1);
            check_comb("halt.hold", 1'b0, 1'b1, FWD_RF, FWD_RF);
            tick(1, 0);
        end
        check_cnt("halt3");
        bus.step_req = 1'b1;
        tick(1, 0);
        bus.step_req = 1'b0;
        check("step.halted", {31'd0, bus.halted}, 32'd0);
        check_comb("step.go", 1'b1, 1'b0, FWD_RF, FWD_RF);
        check("step.ack0", {31'd0, bus.step_ack}, 32'd0);
        tick(0, 0);
        check("step.ack1", {31'd0, bus.step_ack}, 32'd1);
        check("step.back", {31'd0, bus.halted}, 32'd1);
        check_comb("step.hold", 1'b0, 1'b1, FWD_RF, FWD_RF);
        tick(1, 0);
        check("step.ack2", {31'd0, bus.step_ack}, 32'd0);

        bus.step_req = 1'b1;
        tick(1, 0);
        bus.step_req = 1'b0;
        bus.instruction = mk_add(5'd6, 5'd2, 5'd10);
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.erdrt_output = 5'd2;
        check_comb("sblk.ldh", 1'b0, 1'b1, FWD_RF, FWD_RF);
        tick(1, 1);
        check("sblk.ack0", {31'd0, bus.step_ack}, 32'd0);
        clr_pipe();
        check_comb("sblk.go", 1'b1, 1'b0, FWD_RF, FWD_RF);
        tick(0, 0);
        check("sblk.ack1", {31'd0, bus.step_ack}, 32'd1);
        check_cnt("sblk");
        bus.instruction = 32'd0;
        tick(1, 0);

        bus.halt_req = 1'b0;
        tick(1, 0);
        check("resume.halted", {31'd0, bus.halted}, 32'd0);
        check_comb("resume", 1'b1, 1'b0, FWD_RF, FWD_RF);
        tick(0, 0);

        bus.halt_req = 1'b1;
        tick(1, 0);
        bus.step_req = 1'b1;
        tick(1, 0);
        bus.step_req = 1'b0;
        check_comb("mid.step", 1'b1, 1'b0, FWD_RF, FWD_RF);
        do_reset("mid.rst");
        check("sat.zero", {28'd0, sbus.cycle_cnt}, 32'd0);
        // back in RUN with halt_req high: freeze, not an advancing step
        check_comb("mid.run", 1'b0, 1'b1, FWD_RF, FWD_RF);
        tick(1, 0);
        check("mid.halted", {31'd0, bus.halted},   32'd1);
        check("mid.ack",    {31'd0, bus.step_ack}, 32'd0);
        bus.halt_req = 1'b0;
        tick(1, 0);
        for (int i = 0; i < 12; i++) tick(0, 0);
        check("sat.14", {28'd0, sbus.cycle_cnt}, 32'd14);
        tick(0, 0);
        check("sat.15", {28'd0, sbus.cycle_cnt}, 32'd15);
        for (int i = 0; i < 3; i++) tick(0, 0);
        check("sat.hold", {28'd0, sbus.cycle_cnt}, 32'd15);
        check_cnt("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the five-stage load/store datapath (IF, ID, EXE, MEM, WB).
- Inspects the ID-stage instruction against destinations in flight in EXE and MEM, and produces:
  - forwarding selects for the ID/EXE operand muxes;
  - the PC/IFID write enable (`wpcir`);
  - the ID/EXE bubble control.
- Adds run control (halt, single-step with handshake) and saturating performance counters, so the pipeline can be frozen, drained and stepped from the bench or a debug port.

Parameters:
CNT_W, 32, width of each performance counter (saturating).

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instruction  in  32  IF/ID register output (ID-stage instruction)
ewreg  in  1  EXE-stage register-write flag
em2reg  in  1  EXE-stage load flag (result comes from data memory)
erdrt_output  in  5  EXE-stage destination register
mwreg  in  1  MEM-stage register-write flag
mm2reg  in  1  MEM-stage load flag
mrdrt_output  in  5  MEM-stage destination register
halt_req  in  1  level: freeze fetch and drain the pipeline while high
step_req  in  1  one-cycle pulse: release exactly one instruction while halted
wpcir  out  1  PC and IF/ID write enable (0 = hold)
bubble  out  1  1 = zero wreg/m2reg/wmem entering ID/EXE
fwda  out  2  qa source: 00 regfile, 01 EXE alu_out, 10 MEM alu_out, 11 MEM dm_out
fwdb  out  2  qb source, same encoding
step_ack  out  1  one-cycle pulse: stepped instruction entered ID/EXE
halted  out  1  high while in HALT state
cycle_cnt  out  CNT_W  cycles since reset
stall_cnt  out  CNT_W  load-use stall cycles
bubble_cnt  out  CNT_W  cycles with bubble=1 for any reason

Behaviour:

Decode (combinational):
- Fields: op=[31:26], rs=[25:21], rt=[20:16].
- use_rs when op is 000000, 100011 or 101011.
- use_rt when op is 000000 or 101011.
- All other ops use neither field.

Forwarding (combinational), fwda shown (fwdb is identical with rt/use_rt):
- 01 if ewreg and !em2reg and erdrt_output==rs and rs!=0.
- Else 10 if mwreg and !mm2reg and mrdrt_output==rs and rs!=0.
- Else 11 if mwreg and mm2reg and mrdrt_output==rs and rs!=0.
- Else 00.
- EXE always has priority over MEM.
- Register 0 is never forwarded.

Load-use hazard (ldh, combinational):
- ldh = ewreg & em2reg & erdrt_output!=0 & ((use_rs & erdrt_output==rs) | (use_rt & erdrt_output==rt)).

FSM states: RUN, LDSTALL, HALT, STEP. Reset state is RUN.
- RUN:
  - halt_req → HALT.
  - Else ldh → LDSTALL.
  - Else stay RUN.
  - Outputs: wpcir = !(ldh | halt_req); bubble = ldh | halt_req.
- LDSTALL:
  - Outputs: wpcir=1, bubble=0; the load is now in MEM and forwarding selects 11.
  - Next state: HALT if halt_req, else RUN.
  - Lasts exactly one cycle.
- HALT:
  - Outputs: wpcir=0, bubble=1, halted=1.
  - halt_req=0 → RUN.
  - Else step_req=1 → STEP.
  - step_req in any other state is ignored.
- STEP:
  - If ldh: wpcir=0, bubble=1, stay STEP.
  - Else: wpcir=1, bubble=0, → HALT, and step_ack=1 in the following cycle.
  - halt_req dropping during STEP does not abort the step.
- Simultaneous events: halt_req and ldh in RUN → HALT (freeze dominates; the bubble covers the hazard).

Counters:
- cycle_cnt increments every cycle.
- stall_cnt increments when ldh causes wpcir=0 (in RUN or STEP).
- bubble_cnt increments when bubble=1.
- All counters saturate at all-ones.

Reset:
- Synchronous, rst high at a rising edge: state=RUN, step_ack=0, all counters 0.
- Reset in any state, including mid-STEP, returns to RUN with no step_ack.
- During the rst cycle the combinational outputs still reflect the inputs.

Latency:
- wpcir, bubble, fwda and fwdb are same-cycle combinational.
- step_ack is registered, one cycle after the advancing STEP cycle.

Decomposition:
- Shared package:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011;
  - forwarding encodings FWD_RF/FWD_EALU/FWD_MALU/FWD_MDM;
  - FSM state encoding.
- One natural sub-module: hazard_fwd_sel (combinational forwarding selector for one operand), instantiated for rs and rt.
- FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use stall:
  - Stimulus: ID=00000000010010100011000000100000 (add r6,r2,r10), ewreg=1, em2reg=1, erdrt_output=2.
  - Required: wpcir=0, bubble=1, stall_cnt 0→1.
  - Next cycle (mwreg=1, mm2reg=1, mrdrt_output=2, ewreg=0): wpcir=1, fwda=11.
- Forward priority:
  - Stimulus: ID add with rs=5, rt=5; EXE and MEM both write r5 with m2reg=0.
  - Required: fwda=fwdb=01.
  - Then remove the EXE write: fwda=fwdb=10.
- Register-zero and lw-rt:
  - Stimulus: ID lw r2,0(r0); erdrt_output=0 with ewreg=1, and a separate case erdrt_output=2 with em2reg=1.
  - Required: fwda=00, no stall in both cases (rs=0; rt is not a source for lw).
- Halt/step:
  - Stimulus: raise halt_req; after 3 cycles, pulse step_req.
  - Required: halted=1; bubble_cnt += 3; exactly one cycle with wpcir=1, then step_ack=1 for one cycle, then back in HALT.
  - Drop halt_req → RUN, wpcir=1.
- Step blocked by hazard:
  - Stimulus: in STEP with ldh true for 1 cycle.
  - Required: one stall cycle (stall_cnt+1), then advance, then step_ack.
- Reset mid-STEP and saturation:
  - Stimulus: rst asserted in STEP.
  - Required: next cycle state RUN, step_ack=0, counters 0.
  - Stimulus: force cycle_cnt near all-ones with CNT_W=4.
  - Required: holds at 15.
